// File: rtl/seq_addsub_pkg.sv
// seq_addsub shared types: FSM states and operation encodings.
// Optional status outputs are enabled by STATUS_FLAGS_EN.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub.
// zero/neg exist only when STATUS_FLAGS_EN is defined.
interface seq_addsub_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
`ifdef STATUS_FLAGS_EN
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, cin,
    output out_ready,
    input  in_ready, out_valid,
    input  result, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, cin,
    input  out_ready,
    output in_ready, out_valid,
    output result, cout, ovf, zero, neg
  );
`else
  modport master (
    output in_valid, a, b, sub, cin,
    output out_ready,
    input  in_ready, out_valid,
    input  result, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin,
    input  out_ready,
    output in_ready, out_valid,
    output result, cout, ovf
  );
`endif

endinterface

// File: rtl/seq_addsub_chunk_adder.sv
// CHUNK-bit combinational ripple adder built from full adders.
// Also exposes the carry into its top bit for overflow detection.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    fulladder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/sub reusing one CHUNK-bit ripple over WIDTH/CHUNK cycles.
// Define STATUS_FLAGS_EN to add registered zero/neg outputs.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic        clk,
  input logic        rst_n,
  seq_addsub_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             cout_q;
  logic             ovf_q;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] cs;
  logic             cc;
  logic             cm;
  logic             accept;
  logic             last;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (idx == IW'(NCH - 1));
  assign ca     = opa[idx*CHUNK +: CHUNK];
  assign cb     = opb[idx*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a        (ca),
    .b        (cb),
    .cin      (carry),
    .s        (cs),
    .cout     (cc),
    .c_msb_in (cm)
  );

  always_comb begin
    res_nxt = res_q;
    res_nxt[idx*CHUNK +: CHUNK] = cs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)        state_nxt = BUSY;
      BUSY:    if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // B is inverted at capture so the chunk loop only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      res_q  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            opa   <= bus.a;
            opb   <= bus.b ^ {WIDTH{bus.sub == OP_SUB}};
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        BUSY: begin
          res_q <= res_nxt;
          carry <= cc;
          idx   <= idx + 1'b1;
          if (last) begin
            cout_q <= cc;
            ovf_q  <= cc ^ cm;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STATUS_FLAGS_EN
  logic zero_q;
  logic neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state == BUSY && last) begin
      zero_q <= (res_nxt == '0);
      neg_q  <= res_nxt[WIDTH-1];
    end
  end

  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: vector table, scoreboard, backpressure and reset abort.
// Checks zero/neg too when built with STATUS_FLAGS_EN.
module tb_seq_addsub;
  import addsub_pkg::*;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int NCH = W / C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(W)) bus ();

  seq_addsub #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    int           hold;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic sub, input logic cin,
                                 input int hold);
    vec_t         v;
    logic [W-1:0] bb;
    logic [W:0]   s;
    bb     = sub ? ~b : b;
    s      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    v.a    = a;
    v.b    = b;
    v.sub  = sub;
    v.cin  = cin;
    v.res  = s[W-1:0];
    v.cout = s[W];
    v.ovf  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
    v.hold = hold;
    return v;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sub, input logic cin,
                              input logic [W-1:0] res, input logic cout,
                              input logic ovf, input int hold);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin;
    v.res = res; v.cout = cout; v.ovf = ovf; v.hold = hold;
    return v;
  endfunction

  task automatic scramble();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.sub = 1'($urandom);
    bus.cin = 1'($urandom);
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic run_op(input vec_t v);
    int   lat;
    bit   got;
    vec_t e;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.sub      = v.sub;
    bus.cin      = v.cin;
    bus.in_valid = 1'b1;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.in_ready) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("accept_wait", 32'(got), 32'd1);
    @(posedge clk);
    sb.push_back(v);
    #1;
    bus.in_valid = 1'b0;
    scramble();
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      bus.in_valid = 1'($urandom);
      scramble();
    end
    bus.in_valid = 1'b0;
    check("latency", 32'(lat), 32'(NCH));
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h < v.hold; h++) begin
      bus.in_valid = 1'($urandom);
      scramble();
      @(posedge clk);
      #1;
      check("bp_result", 32'(bus.result), 32'(e.res));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    check("result", 32'(bus.result), 32'(e.res));
    check("cout", 32'(bus.cout), 32'(e.cout));
    check("ovf", 32'(bus.ovf), 32'(e.ovf));
`ifdef STATUS_FLAGS_EN
    check("zero", 32'(bus.zero), 32'(e.res == '0));
    check("neg", 32'(bus.neg), 32'(e.res[W-1]));
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = OP_ADD;
    bus.cin       = 1'b0;

    vecs.push_back(mk(16'h1234, 16'h0FFF, OP_ADD, 1'b0, 16'h2233, 1'b0, 1'b0, 0));
    vecs.push_back(mk(16'h000D, 16'h000B, OP_SUB, 1'b1, 16'h0002, 1'b1, 1'b0, 1));
    vecs.push_back(mk(16'h0009, 16'h000F, OP_SUB, 1'b1, 16'hFFFA, 1'b0, 1'b0, 5));
    vecs.push_back(mk(16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 0));
    vecs.push_back(mk(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 16'h0000, 1'b1, 1'b0, 2));
    vecs.push_back(mk(16'h5555, 16'h5555, OP_SUB, 1'b1, 16'h0000, 1'b1, 1'b0, 0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(model(W'($urandom), W'($urandom), 1'($urandom),
                           1'($urandom), i % 3));
    vecs.push_back(mk(16'h8000, 16'h0001, OP_SUB, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Abort an operation mid-BUSY with an asynchronous reset.
    bus.a        = 16'hABCD;
    bus.b        = 16'h1111;
    bus.sub      = OP_ADD;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    check("abort_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_no_valid", 32'(bus.out_valid), 32'd0);

    run_op(mk(16'hABCD, 16'h1111, OP_ADD, 1'b1, 16'hBCDF, 1'b0, 1'b0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor built from a CHUNK-bit ripple of full adders. It is reused over WIDTH/CHUNK clock cycles, with the inter-chunk carry held in a register. Operands arrive and results leave over valid/ready handshakes. It provides carry/borrow and signed-overflow status, and replaces fixed-width combinational ripple subtractors where area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
NCH (localparam), WIDTH/CHUNK, cycles of computation per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a, b, sub, cin valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  1 = subtract (B inverted), 0 = add.
cin  input  1  carry-in to bit 0; drive 1 for true two's-complement subtraction.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  a + (sub ? ~b : b) + cin, modulo 2^WIDTH.
cout  output  1  carry out of the MSB; in subtract mode cout = 0 means borrow.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Reset is applied immediately on assertion; release is synchronised externally.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, result = 0, cout = 0, ovf = 0, chunk index = 0, carry register = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: latch a, b XORed with {WIDTH{sub}}, and cin into the carry register. Clear the chunk index. Go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, chunk_adder adds chunk[idx] of A and B' plus the carry register.
  - The sum is written into result[idx*CHUNK +: CHUNK]. The carry register takes the chunk carry-out. idx increments.
  - On the edge where idx == NCH-1: latch cout and ovf (using the MSB carry-in from this last chunk), then go to DONE.
- DONE:
  - out_valid = 1; result, cout and ovf are held stable.
  - On out_valid & out_ready: go to IDLE. out_valid drops on the next cycle.
- Latency and throughput:
  - out_valid rises exactly NCH cycles after the accepting edge.
  - Throughput is one operation per NCH+2 cycles when out_ready is held high.
- Mid-operation inputs: changes on a, b, sub, cin or in_valid during BUSY/DONE have no effect. Operands are captured only at the accept edge.
- Backpressure: while out_ready = 0, the block stays in DONE indefinitely with outputs frozen.
- Reset mid-operation: the operation is aborted and all outputs return to their reset values. No partial result is ever presented.
- CHUNK == WIDTH: NCH = 1. Degenerates to a registered single-cycle adder; the protocol is unchanged.
- Wrap-around: result is always taken modulo 2^WIDTH. cout and ovf are independent flags.

Optional Feature:
STATUS_FLAGS_EN — when defined, adds two outputs, each 1 bit wide:
- zero: result == 0.
- neg: result[WIDTH-1].

Both are registered alongside cout/ovf, valid with out_valid, and reset to 0. When the macro is undefined, these ports and their logic are absent.

Decomposition:
Package addsub_pkg contains:
- state_t enum {IDLE, BUSY, DONE}.
- op encodings OP_ADD = 1'b0 and OP_SUB = 1'b1.

Sub-module chunk_adder (combinational, parameter CHUNK):
- Inputs: a, b, cin.
- Outputs: s, cout, and c_msb_in (carry into its top bit).
- Built as a ripple of fulladder instances.

seq_addsub holds the FSM, operand registers, carry register and index counter.

Test Plan:
Use WIDTH = 16, CHUNK = 4.
- Reset: assert rst_n = 0 mid-BUSY -> immediately out_valid = 0, result = 0, cout = 0, ovf = 0; after release, in_ready = 1.
- Add: a = 16'h1234, b = 16'h0FFF, sub = 0, cin = 0 -> result = 16'h2233, cout = 0, ovf = 0; out_valid exactly 4 cycles after the accept edge.
- Subtract, no borrow: a = 16'h000D, b = 16'h000B, sub = 1, cin = 1 -> result = 16'h0002, cout = 1, ovf = 0.
- Subtract with borrow: a = 16'h0009, b = 16'h000F, sub = 1, cin = 1 -> result = 16'hFFFA, cout = 0, ovf = 0.
- Signed overflow: a = 16'h7FFF, b = 16'h0001, add, cin = 0 -> result = 16'h8000, cout = 0, ovf = 1. Also a = 16'h8000 minus b = 16'h0001 -> result = 16'h7FFF, cout = 1, ovf = 1.
- Backpressure: hold out_ready = 0 for 5 cycles and toggle in_valid and the operands meanwhile -> result stays stable, in_ready = 0, the new operands are ignored; the next accept happens only after the out handshake and the return to IDLE.
